// File: rtl/rs_issue_queue_pkg.sv
// Shared definitions for the integer reservation station.
//   - Default operand/tag/opcode widths.
//   - Opcode encodings seen by the integer ALU.
//   - tag_match(): wakeup comparator used for both dispatch forwarding
//     and entry wakeup. Tags are zero-extended to TAG_MAX by the caller.
package rs_issue_queue_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int ROB_W_DEF = 4;
    localparam int OP_W_DEF  = 6;
    localparam int TAG_MAX   = 16;

    localparam logic [OP_W_DEF-1:0] OP_ADD  = 6'h00;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 6'h01;
    localparam logic [OP_W_DEF-1:0] OP_AND  = 6'h02;
    localparam logic [OP_W_DEF-1:0] OP_OR   = 6'h03;
    localparam logic [OP_W_DEF-1:0] OP_XOR  = 6'h04;
    localparam logic [OP_W_DEF-1:0] OP_ADDI = 6'h08;
    localparam logic [OP_W_DEF-1:0] OP_JALR = 6'h10;

    function automatic logic tag_match(input logic               bus_valid,
                                       input logic [TAG_MAX-1:0] bus_tag,
                                       input logic [TAG_MAX-1:0] op_tag);
        return bus_valid && (bus_tag == op_tag);
    endfunction

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, writeback-snoop and issue signals of the reservation station.
//   master: dispatch stage / writeback buses / ALU (drives requests).
//   slave : the reservation station.
// Handshakes: a dispatch transfers on a rising edge where disp_valid and
// disp_ready are both high (and the station is enabled and not flushing);
// an issue transfers on a rising edge where iss_valid and iss_ready are both
// high. A valid side never waits on its ready, and iss_* stays stable while
// iss_valid is high and iss_ready is low. wb_* buses have no handshake: a
// set wb_valid bit is a one-cycle broadcast.
interface rs_issue_queue_if
    import rs_issue_queue_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int NUM_WB = 2
);
    logic                    disp_valid;
    logic                    disp_ready;
    logic [OP_W-1:0]         disp_op;
    logic [ROB_W-1:0]        disp_rob;
    logic                    disp_rs1_rdy;
    logic                    disp_rs2_rdy;
    logic [XLEN-1:0]         disp_rs1;
    logic [XLEN-1:0]         disp_rs2;
    logic                    disp_use_imm;
    logic [XLEN-1:0]         disp_imm;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*ROB_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_data;
    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [XLEN-1:0]         iss_v1;
    logic [XLEN-1:0]         iss_v2;
    logic [ROB_W-1:0]        iss_rob;

    modport master (
        output disp_valid, disp_op, disp_rob, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1, disp_rs2, disp_use_imm, disp_imm,
               wb_valid, wb_tag, wb_data, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_v1, iss_v2, iss_rob
    );

    modport slave (
        input  disp_valid, disp_op, disp_rob, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1, disp_rs2, disp_use_imm, disp_imm,
               wb_valid, wb_tag, wb_data, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_v1, iss_v2, iss_rob
    );
endinterface

// File: rtl/rs_issue_queue_age_select.sv
// rs_age_select: age matrix plus oldest-ready picker.
//   clk, rst_n  : clock, async active-low reset
//   alloc_en    : an entry is written this cycle at alloc_idx
//   alloc_idx   : slot being allocated
//   valid_vec   : registered valid bits of all slots
//   cand_vec    : slots that are valid with both operands ready
//   grant       : one-hot oldest candidate (all zero when none)
// older_q[i][j] = 1 means slot j was dispatched before slot i. Rows of
// invalid slots are stale but harmless: a slot's column is cleared in every
// row when it is reallocated, and its own row is rewritten at the same time.
module rs_age_select #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic [DEPTH-1:0]         valid_vec,
    input  logic [DEPTH-1:0]         cand_vec,
    output logic [DEPTH-1:0]         grant
);
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    always_comb begin
        older_d = older_q;
        if (alloc_en) begin
            for (int j = 0; j < DEPTH; j++) older_d[j][alloc_idx] = 1'b0;
            // The new slot is younger than everything currently valid.
            older_d[alloc_idx] = valid_vec;
        end
    end

    // Ages form a total order over valid slots, so at most one bit is set.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++)
            grant[i] = cand_vec[i] && ((older_q[i] & cand_vec) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            older_q <= older_d;
        end
    end
endmodule

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: age-ordered integer reservation station.
//   clk, rst_n : clock, async active-low reset
//   rdy        : global enable, all state holds while low
//   flush      : drop every entry and the issue register on the next edge
//   io         : dispatch port, NUM_WB writeback snoop buses, issue port
//   count      : occupied entries (the issue register is not counted)
// Entries wake up from the buses, the oldest fully-ready entry is moved
// into a registered issue stage that honours iss_ready back-pressure.
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int XLEN   = XLEN_DEF,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int NUM_WB = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic                   flush,
    rs_issue_queue_if.slave        io,
    output logic [$clog2(DEPTH):0] count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0] valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [OP_W-1:0]  op_d  [DEPTH];
    logic [ROB_W-1:0] rob_q [DEPTH];
    logic [ROB_W-1:0] rob_d [DEPTH];
    logic [XLEN-1:0]  v1_q  [DEPTH];
    logic [XLEN-1:0]  v1_d  [DEPTH];
    logic [XLEN-1:0]  v2_q  [DEPTH];
    logic [XLEN-1:0]  v2_d  [DEPTH];

    logic             iss_valid_q, iss_valid_d;
    logic [OP_W-1:0]  iss_op_q, iss_op_d;
    logic [ROB_W-1:0] iss_rob_q, iss_rob_d;
    logic [XLEN-1:0]  iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] cand, grant;
    logic [IDX_W-1:0] alloc_idx, win_idx;
    logic             disp_ready, alloc_en, load;

    // Returns {hit, data}; lower bus index wins because it is applied last.
    function automatic logic [XLEN:0] snoop(input logic [ROB_W-1:0]        tag,
                                            input logic [NUM_WB-1:0]       v,
                                            input logic [NUM_WB*ROB_W-1:0] t,
                                            input logic [NUM_WB*XLEN-1:0]  d);
        logic [XLEN:0] r;
        r = '0;
        for (int k = NUM_WB - 1; k >= 0; k--)
            if (tag_match(v[k], TAG_MAX'(t[k*ROB_W +: ROB_W]), TAG_MAX'(tag)))
                r = {1'b1, d[k*XLEN +: XLEN]};
        return r;
    endfunction

    assign cand       = valid_q & r1_q & r2_q;
    // Registered count only: a slot freed this cycle is not offered until next.
    assign disp_ready = (count_q != CNT_W'(DEPTH));
    assign alloc_en   = rdy && !flush && io.disp_valid && disp_ready;
    assign load       = rdy && !flush && (!iss_valid_q || io.iss_ready) && (grant != '0);

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid_q[i]) alloc_idx = i[IDX_W-1:0];
        win_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (grant[i]) win_idx = i[IDX_W-1:0];
    end

    rs_age_select #(.DEPTH(DEPTH)) u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .valid_vec (valid_q),
        .cand_vec  (cand),
        .grant     (grant)
    );

    always_comb begin
        logic [XLEN:0] s;
        s           = '0;
        valid_d     = valid_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        op_d        = op_q;
        rob_d       = rob_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_rob_d   = iss_rob_q;
        iss_v1_d    = iss_v1_q;
        iss_v2_d    = iss_v2_q;
        count_d     = count_q;
        if (rdy) begin
            if (flush) begin
                valid_d     = '0;
                iss_valid_d = 1'b0;
                count_d     = '0;
            end else begin
                // Wakeup: a waiting operand holds its ROB tag in the low bits.
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && !r1_q[i]) begin
                        s = snoop(v1_q[i][ROB_W-1:0], io.wb_valid, io.wb_tag, io.wb_data);
                        if (s[XLEN]) begin
                            v1_d[i] = s[XLEN-1:0];
                            r1_d[i] = 1'b1;
                        end
                    end
                    if (valid_q[i] && !r2_q[i]) begin
                        s = snoop(v2_q[i][ROB_W-1:0], io.wb_valid, io.wb_tag, io.wb_data);
                        if (s[XLEN]) begin
                            v2_d[i] = s[XLEN-1:0];
                            r2_d[i] = 1'b1;
                        end
                    end
                end
                if (!iss_valid_q || io.iss_ready) begin
                    iss_valid_d = load;
                    if (load) begin
                        iss_op_d         = op_q[win_idx];
                        iss_rob_d        = rob_q[win_idx];
                        iss_v1_d         = v1_q[win_idx];
                        iss_v2_d         = v2_q[win_idx];
                        valid_d[win_idx] = 1'b0;
                    end
                end
                if (alloc_en) begin
                    valid_d[alloc_idx] = 1'b1;
                    op_d[alloc_idx]    = io.disp_op;
                    rob_d[alloc_idx]   = io.disp_rob;
                    s = snoop(io.disp_rs1[ROB_W-1:0], io.wb_valid, io.wb_tag, io.wb_data);
                    r1_d[alloc_idx] = io.disp_rs1_rdy || s[XLEN];
                    v1_d[alloc_idx] = (!io.disp_rs1_rdy && s[XLEN]) ? s[XLEN-1:0] : io.disp_rs1;
                    if (io.disp_use_imm) begin
                        r2_d[alloc_idx] = 1'b1;
                        v2_d[alloc_idx] = io.disp_imm;
                    end else begin
                        s = snoop(io.disp_rs2[ROB_W-1:0], io.wb_valid, io.wb_tag, io.wb_data);
                        r2_d[alloc_idx] = io.disp_rs2_rdy || s[XLEN];
                        v2_d[alloc_idx] = (!io.disp_rs2_rdy && s[XLEN]) ? s[XLEN-1:0] : io.disp_rs2;
                    end
                end
                count_d = count_q + CNT_W'(alloc_en) - CNT_W'(load);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_rob_q   <= '0;
            iss_v1_q    <= '0;
            iss_v2_q    <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_rob_q   <= iss_rob_d;
            iss_v1_q    <= iss_v1_d;
            iss_v2_q    <= iss_v2_d;
            count_q     <= count_d;
        end
    end

    // Payload storage is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        rob_q <= rob_d;
        v1_q  <= v1_d;
        v2_q  <= v2_d;
    end

    assign io.disp_ready = disp_ready;
    assign io.iss_valid  = iss_valid_q;
    assign io.iss_op     = iss_op_q;
    assign io.iss_rob    = iss_rob_q;
    assign io.iss_v1     = iss_v1_q;
    assign io.iss_v2     = iss_v2_q;
    assign count         = count_q;
endmodule

// File: tb/tb_rs_issue_queue.sv
module tb_rs_issue_queue;
  import rs_issue_queue_pkg::*;

  localparam int DEPTH  = 8;
  localparam int XLEN   = 32;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 6;
  localparam int NUM_WB = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk, rst_n, rdy, flush;
  logic [CW-1:0] count;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rs_issue_queue_if #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_WB(NUM_WB)) bus ();

  rs_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_WB(NUM_WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .flush (flush),
    .io    (bus),
    .count (count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // The station is an age-ordered list: dispatch appends, issue removes
  // the first entry whose operands are both ready.
  typedef struct {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  v1, v2;
    logic             r1, r2;
    logic [ROB_W-1:0] t1, t2;
  } ent_t;

  ent_t mq[$];
  logic             m_iss_valid;
  logic [OP_W-1:0]  m_op;
  logic [ROB_W-1:0] m_rob;
  logic [XLEN-1:0]  m_v1, m_v2;
  logic [XLEN-1:0] exp_q[$];  // expected iss_v1 values of accepted issues, random phase

  function automatic bit bus_hit(input logic [ROB_W-1:0] tag, output logic [XLEN-1:0] d);
    d = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (bus.wb_valid[k] && bus.wb_tag[k*ROB_W +: ROB_W] == tag) begin
        d = bus.wb_data[k*XLEN +: XLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_iss_valid = 1'b0;
    m_op = '0; m_rob = '0; m_v1 = '0; m_v2 = '0;
  endtask

  task automatic model_step();
    int win;
    bit acc, hit;
    ent_t e;
    logic [XLEN-1:0] d;
    if (!rdy) return;
    if (flush) begin
      mq.delete();
      m_iss_valid = 1'b0;
      return;
    end
    acc = bus.disp_valid && (mq.size() < DEPTH);
    win = -1;
    for (int i = 0; i < mq.size(); i++)
      if (win < 0 && mq[i].r1 && mq[i].r2) win = i;
    if (!m_iss_valid || bus.iss_ready) begin
      if (win >= 0) begin
        m_iss_valid = 1'b1;
        m_op = mq[win].op; m_rob = mq[win].rob; m_v1 = mq[win].v1; m_v2 = mq[win].v2;
        mq.delete(win);
      end else begin
        m_iss_valid = 1'b0;
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].r1) begin
        hit = bus_hit(mq[i].t1, d);
        if (hit) begin mq[i].v1 = d; mq[i].r1 = 1'b1; end
      end
      if (!mq[i].r2) begin
        hit = bus_hit(mq[i].t2, d);
        if (hit) begin mq[i].v2 = d; mq[i].r2 = 1'b1; end
      end
    end
    if (acc) begin
      e.op = bus.disp_op; e.rob = bus.disp_rob;
      e.t1 = bus.disp_rs1[ROB_W-1:0]; e.v1 = bus.disp_rs1; e.r1 = bus.disp_rs1_rdy;
      if (!e.r1) begin
        hit = bus_hit(e.t1, d);
        if (hit) begin e.v1 = d; e.r1 = 1'b1; end
      end
      if (bus.disp_use_imm) begin
        e.t2 = '0; e.v2 = bus.disp_imm; e.r2 = 1'b1;
      end else begin
        e.t2 = bus.disp_rs2[ROB_W-1:0]; e.v2 = bus.disp_rs2; e.r2 = bus.disp_rs2_rdy;
        if (!e.r2) begin
          hit = bus_hit(e.t2, d);
          if (hit) begin e.v2 = d; e.r2 = 1'b1; end
        end
      end
      mq.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_rob = '0;
    bus.disp_rs1_rdy = 1'b0; bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs1 = '0; bus.disp_rs2 = '0; bus.disp_use_imm = 1'b0; bus.disp_imm = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_data = '0;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                          input logic r1, input logic [XLEN-1:0] v1,
                          input logic r2, input logic [XLEN-1:0] v2,
                          input logic use_imm, input logic [XLEN-1:0] imm);
    bus.disp_valid = 1'b1; bus.disp_op = op; bus.disp_rob = rob;
    bus.disp_rs1_rdy = r1; bus.disp_rs1 = v1; bus.disp_rs2_rdy = r2; bus.disp_rs2 = v2;
    bus.disp_use_imm = use_imm; bus.disp_imm = imm;
  endtask

  // Advance one clock; inputs are applied before the edge, outputs are
  // sampled 1 time unit after it.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.iss_ready = 1'b0;
    #1;
    n_checks++; if (bus.iss_valid !== 1'b0) begin n_errors++; $display("FAIL por_iss_valid got=%0b exp=0", bus.iss_valid); end
    n_checks++; if (count !== '0) begin n_errors++; $display("FAIL por_count got=%0d exp=0", count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    // Build state: one op in the issue register, one waiting in an entry.
    set_disp(OP_ADD, 4'd9, 1'b1, 32'd1, 1'b1, 32'd2, 1'b0, '0);
    step();
    set_disp(OP_SUB, 4'd10, 1'b1, 32'd3, 1'b1, 32'd4, 1'b0, '0);
    step();
    idle();
    step();
    n_checks++; if (bus.iss_valid !== 1'b1 || count !== CW'(1)) begin n_errors++; $display("FAIL pre_reset_state iss_valid=%0b count=%0d exp 1/1", bus.iss_valid, count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.iss_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset_iss_valid got=%0b exp=0", bus.iss_valid); end
    n_checks++; if (count !== '0) begin n_errors++; $display("FAIL mid_reset_count got=%0d exp=0", count); end
    n_checks++; if (bus.disp_ready !== 1'b1) begin n_errors++; $display("FAIL mid_reset_disp_ready got=%0b exp=1", bus.disp_ready); end
    n_checks++; if (bus.iss_rob !== '0 || bus.iss_v1 !== '0 || bus.iss_op !== '0) begin n_errors++; $display("FAIL mid_reset_payload rob=%0d v1=%h op=%0d exp 0", bus.iss_rob, bus.iss_v1, bus.iss_op); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_age_order();
    logic [ROB_W-1:0] exp_rob [3];
    exp_rob[0] = 4'd3; exp_rob[1] = 4'd5; exp_rob[2] = 4'd1;
    idle();
    bus.iss_ready = 1'b1;
    set_disp(OP_ADD, 4'd3, 1'b1, 32'h30, 1'b1, 32'h31, 1'b0, '0);
    step();
    n_checks++; if (bus.iss_valid !== 1'b0) begin n_errors++; $display("FAIL age_early_issue got=%0b exp=0", bus.iss_valid); end
    set_disp(OP_SUB, 4'd5, 1'b1, 32'h50, 1'b1, 32'h51, 1'b0, '0);
    step();
    set_disp(OP_XOR, 4'd1, 1'b1, 32'h10, 1'b1, 32'h11, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.iss_valid !== 1'b1 || bus.iss_rob !== exp_rob[i]) begin
        n_errors++; $display("FAIL age_order_%0d valid=%0b rob=%0d exp valid=1 rob=%0d", i, bus.iss_valid, bus.iss_rob, exp_rob[i]);
      end
      step();
      idle();
    end
    n_checks++; if (bus.iss_valid !== 1'b0) begin n_errors++; $display("FAIL age_drain got=%0b exp=0", bus.iss_valid); end
  endtask

  task automatic test_forward_wakeup();
    idle();
    bus.iss_ready = 1'b1;
    // Same-cycle forwarding from bus 1.
    set_disp(OP_ADD, 4'd2, 1'b0, 32'h7, 1'b1, 32'h5, 1'b0, '0);
    bus.wb_valid = 2'b10; bus.wb_tag = {4'd7, 4'd0}; bus.wb_data = {32'h10, 32'h0};
    step(); idle(); step();
    n_checks++; if (bus.iss_valid !== 1'b1 || bus.iss_v1 !== 32'h10 || bus.iss_v2 !== 32'h5 || bus.iss_op !== OP_ADD) begin
      n_errors++; $display("FAIL fwd_bus1 valid=%0b v1=%h v2=%h op=%0d exp 1/10/5/%0d", bus.iss_valid, bus.iss_v1, bus.iss_v2, bus.iss_op, OP_ADD); end
    // Both buses carry the same tag: bus 0 wins.
    set_disp(OP_SUB, 4'd4, 1'b0, 32'h9, 1'b0, 32'h9, 1'b0, '0);
    bus.wb_valid = 2'b11; bus.wb_tag = {4'd9, 4'd9}; bus.wb_data = {32'hB1, 32'hA0};
    step(); idle(); step();
    n_checks++; if (bus.iss_valid !== 1'b1 || bus.iss_v1 !== 32'hA0 || bus.iss_v2 !== 32'hA0 || bus.iss_rob !== 4'd4) begin
      n_errors++; $display("FAIL fwd_priority valid=%0b v1=%h v2=%h rob=%0d exp 1/a0/a0/4", bus.iss_valid, bus.iss_v1, bus.iss_v2, bus.iss_rob); end
    // Stored entry waits for a later broadcast.
    set_disp(OP_JALR, 4'd6, 1'b0, 32'h4, 1'b1, 32'h8, 1'b0, '0);
    step(); idle(); step(); step();
    n_checks++; if (bus.iss_valid !== 1'b0) begin n_errors++; $display("FAIL wake_wait got=%0b exp=0", bus.iss_valid); end
    bus.wb_valid = 2'b10; bus.wb_tag = {4'd4, 4'd0}; bus.wb_data = {32'hAB, 32'h0};
    step(); idle();
    n_checks++; if (bus.iss_valid !== 1'b0) begin n_errors++; $display("FAIL wake_too_early got=%0b exp=0", bus.iss_valid); end
    step();
    n_checks++; if (bus.iss_valid !== 1'b1 || bus.iss_v1 !== 32'hAB || bus.iss_rob !== 4'd6 || bus.iss_op !== OP_JALR) begin
      n_errors++; $display("FAIL wake_issue valid=%0b v1=%h rob=%0d op=%0d exp 1/ab/6/%0d", bus.iss_valid, bus.iss_v1, bus.iss_rob, bus.iss_op, OP_JALR); end
  endtask

  task automatic test_back_pressure();
    idle();
    bus.iss_ready = 1'b1;
    step();
    set_disp(OP_OR, 4'd15, 1'b1, 32'hF0, 1'b1, 32'hF1, 1'b0, '0);
    step(); idle();
    bus.iss_ready = 1'b0;
    step();
    n_checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 4'd15 || count !== '0) begin
      n_errors++; $display("FAIL bp_parked valid=%0b rob=%0d count=%0d exp 1/15/0", bus.iss_valid, bus.iss_rob, count); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (bus.disp_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_%0d got=%0b exp=1", i, bus.disp_ready); end
      set_disp(OP_ADD, ROB_W'(i), 1'b1, XLEN'(100 + i), 1'b1, XLEN'(i), 1'b0, '0);
      step();
      n_checks++; if (bus.iss_rob !== 4'd15 || bus.iss_v1 !== 32'hF0) begin n_errors++; $display("FAIL bp_stable_%0d rob=%0d v1=%h exp 15/f0", i, bus.iss_rob, bus.iss_v1); end
    end
    n_checks++; if (bus.disp_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      n_errors++; $display("FAIL bp_full ready=%0b count=%0d exp 0/%0d", bus.disp_ready, count, DEPTH); end
    set_disp(OP_ADD, 4'd14, 1'b1, 32'h1, 1'b1, 32'h1, 1'b0, '0);
    step(); idle();
    n_checks++; if (count !== CW'(DEPTH) || bus.iss_rob !== 4'd15) begin
      n_errors++; $display("FAIL bp_reject count=%0d rob=%0d exp %0d/15", count, bus.iss_rob, DEPTH); end
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    n_checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob !== 4'd0 || bus.iss_v1 !== 32'd100) begin
      n_errors++; $display("FAIL bp_one_accept valid=%0b rob=%0d v1=%h exp 1/0/64", bus.iss_valid, bus.iss_rob, bus.iss_v1); end
    n_checks++; if (bus.disp_ready !== 1'b1 || count !== CW'(DEPTH - 1)) begin
      n_errors++; $display("FAIL bp_slot_free ready=%0b count=%0d exp 1/%0d", bus.disp_ready, count, DEPTH - 1); end
  endtask

  task automatic test_flush();
    // Entries pending, issue register full, ALU ready: everything collides.
    idle();
    bus.iss_ready = 1'b1;
    set_disp(OP_SUB, 4'd13, 1'b1, 32'hD0, 1'b1, 32'hD1, 1'b0, '0);
    bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd2}; bus.wb_data = {32'h0, 32'h22};
    flush = 1'b1;
    step(); idle();
    n_checks++; if (count !== '0 || bus.iss_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_clear count=%0d valid=%0b exp 0/0", count, bus.iss_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_errors++; $display("FAIL flush_no_issue_%0d valid=%0b rob=%0d exp 0", i, bus.iss_valid, bus.iss_rob); end
    end
  endtask

  task automatic test_immediate();
    idle();
    bus.iss_ready = 1'b1;
    set_disp(OP_ADDI, 4'd11, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h6, 1'b1, 32'h1);
    bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, 4'd6}; bus.wb_data = {32'h0, 32'h77};
    step(); idle(); step();
    n_checks++; if (bus.iss_valid !== 1'b1 || bus.iss_op !== OP_ADDI || bus.iss_v1 !== 32'hFFFF_FFFF || bus.iss_v2 !== 32'h1) begin
      n_errors++; $display("FAIL imm valid=%0b op=%0d v1=%h v2=%h exp 1/%0d/ffffffff/1", bus.iss_valid, bus.iss_op, bus.iss_v1, bus.iss_v2, OP_ADDI); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] x;
    int n_issued;
    n_issued = 0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 63) == 0);
      bus.iss_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) != 0) begin
        bus.disp_valid = 1'b1;
        bus.disp_op = OP_W'($urandom_range(0, 16));
        bus.disp_rob = ROB_W'($urandom_range(0, 15));
        bus.disp_rs1_rdy = $urandom_range(0, 1);
        bus.disp_rs2_rdy = $urandom_range(0, 1);
        x = $urandom(); x[ROB_W-1:0] = ROB_W'($urandom_range(0, 3)); bus.disp_rs1 = x;
        x = $urandom(); x[ROB_W-1:0] = ROB_W'($urandom_range(0, 3)); bus.disp_rs2 = x;
        bus.disp_use_imm = ($urandom_range(0, 3) == 0);
        bus.disp_imm = $urandom();
      end
      for (int k = 0; k < NUM_WB; k++) begin
        bus.wb_valid[k] = ($urandom_range(0, 9) < 3);
        bus.wb_tag[k*ROB_W +: ROB_W] = ROB_W'($urandom_range(0, 3));
        bus.wb_data[k*XLEN +: XLEN] = $urandom();
      end
      // An issue handshake completing on this edge retires the model's payload.
      if (rdy && !flush && bus.iss_valid && bus.iss_ready) begin
        exp_q.push_back(m_v1);
        n_issued++;
      end
      step();
      n_checks++; if (bus.iss_valid !== m_iss_valid) begin n_errors++; $display("FAIL rand_iss_valid cyc=%0d got=%0b exp=%0b", c, bus.iss_valid, m_iss_valid); end
      n_checks++; if (count !== CW'(mq.size())) begin n_errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, count, mq.size()); end
      n_checks++; if (bus.disp_ready !== (mq.size() != DEPTH)) begin n_errors++; $display("FAIL rand_disp_ready cyc=%0d got=%0b exp=%0b", c, bus.disp_ready, mq.size() != DEPTH); end
      if (m_iss_valid) begin
        n_checks++;
        if (bus.iss_op !== m_op || bus.iss_rob !== m_rob || bus.iss_v1 !== m_v1 || bus.iss_v2 !== m_v2) begin
          n_errors++;
          $display("FAIL rand_payload cyc=%0d got op=%0d rob=%0d v1=%h v2=%h exp op=%0d rob=%0d v1=%h v2=%h",
                   c, bus.iss_op, bus.iss_rob, bus.iss_v1, bus.iss_v2, m_op, m_rob, m_v1, m_v2);
        end
      end
    end
    n_checks++; if (n_issued < 200) begin n_errors++; $display("FAIL rand_throughput issued=%0d exp>=200", n_issued); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus.iss_ready = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_age_order();
    test_forward_wakeup();
    test_back_pressure();
    test_flush();
    test_immediate();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
